// File: rtl/intr_controller.sv
// rtl/intr_controller.sv - edge-triggered, fixed-priority, masked interrupt controller
// Latches request edges as pending and hands one at a time to the CPU via ack/eoi.
module intr_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fuentes,
  input  logic       we_mascara,
  input  logic [7:0] dato_mascara,
  input  logic       ack,
  input  logic       eoi,
  output logic [7:0] interrupcion,
  output logic [7:0] pendientes,
  output logic [7:0] en_servicio,
  output logic [7:0] perdidas
);

  typedef enum logic [1:0] {ESPERA, PETICION, SERVICIO} estado_t;

  estado_t    estado;
  logic [7:0] fuentes_q;
  logic [7:0] mascara;
  logic [2:0] sel;

  logic [7:0] flanco;
  logic [7:0] solicitud;
  logic [7:0] borrar;
  logic [2:0] prio;
  logic       perdida;

  assign flanco    = fuentes & ~fuentes_q;
  assign solicitud = pendientes & mascara;
  assign borrar    = (estado == PETICION && ack) ? (8'h01 << sel) : 8'h00;
  assign perdida   = |(flanco & pendientes);

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    prio = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (solicitud[i]) prio = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado       <= ESPERA;
      fuentes_q    <= 8'h00;
      mascara      <= 8'hFF;
      sel          <= 3'd0;
      interrupcion <= 8'h00;
      pendientes   <= 8'h00;
      en_servicio  <= 8'h00;
      perdidas     <= 8'h00;
    end else begin
      fuentes_q  <= fuentes;
      // A fresh edge on the acknowledged source wins over its clear.
      pendientes <= (pendientes & ~borrar) | flanco;
      if (perdida && perdidas != 8'hFF) perdidas <= perdidas + 8'd1;
      if (we_mascara) mascara <= dato_mascara;

      case (estado)
        ESPERA: begin
          if (|solicitud) begin
            sel          <= prio;
            interrupcion <= 8'h01 << prio;
            estado       <= PETICION;
          end
        end
        PETICION: begin
          if (ack) begin
            interrupcion <= 8'h00;
            en_servicio  <= 8'h01 << sel;
            estado       <= SERVICIO;
          end
        end
        SERVICIO: begin
          if (eoi) begin
            en_servicio <= 8'h00;
            estado      <= ESPERA;
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// tb/tb_intr_controller.sv - directed self-checking bench for intr_controller
module tb_intr_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] fuentes;
  logic       we_mascara;
  logic [7:0] dato_mascara;
  logic       ack;
  logic       eoi;
  logic [7:0] interrupcion;
  logic [7:0] pendientes;
  logic [7:0] en_servicio;
  logic [7:0] perdidas;

  int vectors = 0;
  int miscompares = 0;

  intr_controller dut (
    .clk          (clk),
    .reset        (reset),
    .fuentes      (fuentes),
    .we_mascara   (we_mascara),
    .dato_mascara (dato_mascara),
    .ack          (ack),
    .eoi          (eoi),
    .interrupcion (interrupcion),
    .pendientes   (pendientes),
    .en_servicio  (en_servicio),
    .perdidas     (perdidas)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".int"}, interrupcion, 8'h00);
    check({tag, ".pend"}, pendientes, 8'h00);
    check({tag, ".serv"}, en_servicio, 8'h00);
    check({tag, ".lost"}, perdidas, 8'h00);
  endtask

  initial begin
    int reqs;
    int eoi_cd;

    reset = 1'b1; fuentes = 8'h00; we_mascara = 1'b0; dato_mascara = 8'h00;
    ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();
    check_all_zero("rst_rel");

    // Basic flow on source 0 (also proves mask resets to FF)
    fuentes = 8'h01; tick();
    check("basic.pend", pendientes, 8'h01);
    check("basic.int_n", interrupcion, 8'h00);
    fuentes = 8'h00; tick();
    check("basic.int_n1", interrupcion, 8'h01);
    ack = 1'b1; tick(); ack = 1'b0;
    check("basic.ack_int", interrupcion, 8'h00);
    check("basic.ack_serv", en_servicio, 8'h01);
    check("basic.ack_pend", pendientes, 8'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("basic.eoi_serv", en_servicio, 8'h00);

    // Priority: sources 5 and 2 together
    fuentes = 8'h24; tick();
    fuentes = 8'h00; tick();
    check("prio.int", interrupcion, 8'h04);
    check("prio.pend", pendientes, 8'h24);
    ack = 1'b1; tick(); ack = 1'b0;
    check("prio.serv", en_servicio, 8'h04);
    check("prio.pend2", pendientes, 8'h20);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("prio.espera_int", interrupcion, 8'h00);
    tick();
    check("prio.second", interrupcion, 8'h20);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("prio.drain", pendientes, 8'h00);

    // Mask
    we_mascara = 1'b1; dato_mascara = 8'hFE; tick(); we_mascara = 1'b0;
    fuentes = 8'h01; tick();
    fuentes = 8'h00; tick(); tick();
    check("mask.pend", pendientes, 8'h01);
    check("mask.int", interrupcion, 8'h00);
    we_mascara = 1'b1; dato_mascara = 8'hFF; tick(); we_mascara = 1'b0;
    check("mask.wr_edge", interrupcion, 8'h00);
    tick();
    check("mask.unmask", interrupcion, 8'h01);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Overrun on source 3
    fuentes = 8'h08; tick();
    fuentes = 8'h00; tick();
    check("ovr.int", interrupcion, 8'h08);
    ack = 1'b1; tick(); ack = 1'b0;
    fuentes = 8'h08; tick();
    fuentes = 8'h00; tick();
    check("ovr.first_lost", perdidas, 8'h00);
    fuentes = 8'h08; tick();
    fuentes = 8'h00; tick();
    check("ovr.pend", pendientes, 8'h08);
    check("ovr.lost1", perdidas, 8'h01);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    check("ovr.re_int", interrupcion, 8'h08);
    fuentes = 8'h08; ack = 1'b1; tick(); fuentes = 8'h00; ack = 1'b0;
    check("ovr.ackset_pend", pendientes, 8'h08);
    check("ovr.ackset_lost", perdidas, 8'h02);
    check("ovr.ackset_serv", en_servicio, 8'h08);
    check("ovr.ackset_int", interrupcion, 8'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    check("ovr.serv3", en_servicio, 8'h08);
    for (int i = 0; i < 302; i++) begin
      fuentes = 8'h08; tick();
      fuentes = 8'h00; tick();
    end
    check("ovr.saturate", perdidas, 8'hFF);

    // Reset in SERVICIO, checked before any clock edge
    reset = 1'b1; #2;
    check_all_zero("rst_serv");
    reset = 1'b0;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    check_all_zero("stray");

    // Reset in PETICION
    fuentes = 8'h02; tick();
    fuentes = 8'h00; tick();
    check("rst_pet.int_before", interrupcion, 8'h02);
    reset = 1'b1; #2;
    check_all_zero("rst_pet");
    reset = 1'b0;
    tick();
    fuentes = 8'h01; tick();
    fuentes = 8'h00; tick();
    check("rst_pet.espera", interrupcion, 8'h01);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();

    // Timer (period 7) on source 0 with a CPU acking after 1 cycle, eoi 3 later
    reqs = 0;
    eoi_cd = 0;
    for (int c = 0; c < 70; c++) begin
      fuentes = (c % 7 == 0) ? 8'h01 : 8'h00;
      ack = (interrupcion == 8'h01);
      if (ack) reqs++;
      eoi = (eoi_cd == 1);
      if (eoi_cd > 0) eoi_cd--;
      if (ack) eoi_cd = 3;
      tick();
    end
    fuentes = 8'h00; ack = 1'b0; eoi = 1'b0;
    check("timer.reqs", 8'(reqs), 8'd10);
    check("timer.lost", perdidas, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
